// File: rtl/cr_kme_fifo_pkg.sv
// rtl/cr_kme_fifo_pkg.sv - shared KME entry FIFO widths, field offsets and entry layout
//
// Used by the write-side packer and the read-side unpacker so both agree on
// where each entry field lives inside the 106-bit FIFO word.
package cr_kme_fifo_pkg;

    localparam int ENTRY_W         = 106;
    localparam int DATA_W          = 96;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_ENTRY = 3;
    localparam int TAG_W           = 6;
    localparam int NWORDS_W        = 2;

    // Field offsets within an entry.
    localparam int ENT_SOP_BIT   = 105;
    localparam int ENT_EOP_BIT   = 104;
    localparam int ENT_NW_LSB    = 102;
    localparam int ENT_TAG_LSB   = 96;
    localparam int ENT_DATA_LSB  = 0;

    // Word k of an entry lives at data[32k+31:32k]; unused words are zero.
    typedef struct packed {
        logic                sop;
        logic                eop;
        logic [NWORDS_W-1:0] nwords_m1;
        logic [TAG_W-1:0]    tag;
        logic [DATA_W-1:0]   data;
    } kme_entry_t;

endpackage

// File: rtl/cr_kme_sat_counter.sv
// rtl/cr_kme_sat_counter.sv - saturating up-counter with synchronous clear
//
// Ports:
//   clk    clock
//   clr_i  synchronous clear (wins over increment)
//   inc_i  increment request; ignored once the count is all-ones
//   cnt_o  current count
module cr_kme_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + WIDTH'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/cr_kme_fifo_packer.sv
// rtl/cr_kme_fifo_packer.sv - packs a 32-bit word stream into 106-bit KME FIFO entries
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_ready/in_data   upstream word handshake and payload
//   in_sop/in_eop/in_tag        packet framing; tag sampled on the sop word
//   cfg_stall_override          debug: write the FIFO even while it reports stall
//   fifo_in/fifo_in_valid       FIFO write data and write enable
//   fifo_in_stall               FIFO full indication
//   fifo_in_stall_override      registered copy of cfg_stall_override
//   proto_err                   one-cycle pulse on a framing violation
//   stall_cycles                saturating count of stalled output cycles
//   entries_written             saturating count of FIFO writes
import cr_kme_fifo_pkg::*;

module cr_kme_fifo_packer #(
    parameter int STALL_CNT_W = 16,
    parameter int ENT_CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_W-1:0]      in_data,
    input  logic                   in_sop,
    input  logic                   in_eop,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic                   cfg_stall_override,
    output logic [ENTRY_W-1:0]     fifo_in,
    output logic                   fifo_in_valid,
    input  logic                   fifo_in_stall,
    output logic                   fifo_in_stall_override,
    output logic                   proto_err,
    output logic [STALL_CNT_W-1:0] stall_cycles,
    output logic [ENT_CNT_W-1:0]   entries_written
);

    // Pack stage
    logic [DATA_W-1:0]   pack_data_q, pack_data_d;
    logic [NWORDS_W-1:0] cnt_q, cnt_d;
    logic                sop_seen_q, sop_seen_d;
    logic                eop_seen_q, eop_seen_d;
    logic                in_pkt_q, in_pkt_d;
    logic                done_q, done_d;
    logic [TAG_W-1:0]    tag_q, tag_d;

    // Output stage
    logic [ENTRY_W-1:0]  out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                ovr_q;
    logic                proto_err_q, proto_err_d;

    logic                wr;
    logic                out_free;
    logic                accept;
    logic [DATA_W-1:0]   base_data;
    logic [NWORDS_W-1:0] base_cnt;
    logic [DATA_W-1:0]   word_data;
    kme_entry_t          new_entry;
    kme_entry_t          held_entry;
    kme_entry_t          load_entry;
    logic                load_out;
    logic                clear_pack;

    assign wr       = out_valid_q & (~fifo_in_stall | ovr_q);
    assign out_free = ~out_valid_q | wr;
    assign in_ready = ~done_q;
    assign accept   = in_valid & in_ready;

    always_comb begin
        // A sop word always starts from an empty pack, discarding any partial.
        base_data = in_sop ? '0 : pack_data_q;
        base_cnt  = in_sop ? '0 : cnt_q;

        word_data = base_data;
        case (base_cnt)
            2'd0:    word_data[31:0]  = in_data;
            2'd1:    word_data[63:32] = in_data;
            default: word_data[95:64] = in_data;
        endcase

        new_entry.sop       = in_sop | sop_seen_q;
        new_entry.eop       = in_eop;
        new_entry.nwords_m1 = base_cnt;
        new_entry.tag       = in_sop ? in_tag : tag_q;
        new_entry.data      = word_data;

        held_entry.sop       = sop_seen_q;
        held_entry.eop       = eop_seen_q;
        held_entry.nwords_m1 = cnt_q - 2'd1;
        held_entry.tag       = tag_q;
        held_entry.data      = pack_data_q;
    end

    always_comb begin
        pack_data_d = pack_data_q;
        cnt_d       = cnt_q;
        sop_seen_d  = sop_seen_q;
        eop_seen_d  = eop_seen_q;
        in_pkt_d    = in_pkt_q;
        done_d      = done_q;
        tag_d       = tag_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        proto_err_d = 1'b0;
        load_out    = 1'b0;
        load_entry  = held_entry;
        clear_pack  = 1'b0;

        if (done_q) begin
            if (out_free) begin
                load_out   = 1'b1;
                clear_pack = 1'b1;
            end
        end else if (accept) begin
            if (!in_sop && !in_pkt_q) begin
                // Stray word outside a packet: dropped.
                proto_err_d = 1'b1;
            end else begin
                proto_err_d = in_sop & in_pkt_q;
                in_pkt_d    = ~in_eop;
                tag_d       = new_entry.tag;
                if (in_eop || (base_cnt == 2'd2)) begin
                    if (out_free) begin
                        // Bypass the pack register so the entry shows next cycle.
                        load_out   = 1'b1;
                        load_entry = new_entry;
                        clear_pack = 1'b1;
                    end else begin
                        done_d      = 1'b1;
                        pack_data_d = word_data;
                        cnt_d       = base_cnt + 2'd1;
                        sop_seen_d  = new_entry.sop;
                        eop_seen_d  = in_eop;
                    end
                end else begin
                    pack_data_d = word_data;
                    cnt_d       = base_cnt + 2'd1;
                    sop_seen_d  = new_entry.sop;
                    eop_seen_d  = 1'b0;
                end
            end
        end

        if (clear_pack) begin
            pack_data_d = '0;
            cnt_d       = '0;
            sop_seen_d  = 1'b0;
            eop_seen_d  = 1'b0;
            done_d      = 1'b0;
        end

        if (load_out) begin
            out_data_d  = load_entry;
            out_valid_d = 1'b1;
        end else if (wr) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pack_data_q <= '0;
            cnt_q       <= '0;
            sop_seen_q  <= 1'b0;
            eop_seen_q  <= 1'b0;
            in_pkt_q    <= 1'b0;
            done_q      <= 1'b0;
            tag_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ovr_q       <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            pack_data_q <= pack_data_d;
            cnt_q       <= cnt_d;
            sop_seen_q  <= sop_seen_d;
            eop_seen_q  <= eop_seen_d;
            in_pkt_q    <= in_pkt_d;
            done_q      <= done_d;
            tag_q       <= tag_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovr_q       <= cfg_stall_override;
            proto_err_q <= proto_err_d;
        end
    end

    cr_kme_sat_counter #(.WIDTH(STALL_CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_i (~rst_n),
        .inc_i (out_valid_q & fifo_in_stall & ~ovr_q),
        .cnt_o (stall_cycles)
    );

    cr_kme_sat_counter #(.WIDTH(ENT_CNT_W)) u_ent_cnt (
        .clk   (clk),
        .clr_i (~rst_n),
        .inc_i (wr),
        .cnt_o (entries_written)
    );

    assign fifo_in                = out_data_q;
    assign fifo_in_valid          = wr;
    assign fifo_in_stall_override = ovr_q;
    assign proto_err              = proto_err_q;

endmodule

// File: tb/tb_cr_kme_fifo_packer.sv
// tb/tb_cr_kme_fifo_packer.sv - self-checking bench for cr_kme_fifo_packer
module tb_cr_kme_fifo_packer;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_sop;
    logic         in_eop;
    logic [5:0]   in_tag;
    logic         cfg_stall_override;
    logic [105:0] fifo_in;
    logic         fifo_in_valid;
    logic         fifo_in_stall;
    logic         fifo_in_stall_override;
    logic         proto_err;
    logic [3:0]   stall_cycles;
    logic [15:0]  entries_written;

    int checks;
    int failures;

    cr_kme_fifo_packer #(.STALL_CNT_W(4), .ENT_CNT_W(16)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .in_valid               (in_valid),
        .in_ready               (in_ready),
        .in_data                (in_data),
        .in_sop                 (in_sop),
        .in_eop                 (in_eop),
        .in_tag                 (in_tag),
        .cfg_stall_override     (cfg_stall_override),
        .fifo_in                (fifo_in),
        .fifo_in_valid          (fifo_in_valid),
        .fifo_in_stall          (fifo_in_stall),
        .fifo_in_stall_override (fifo_in_stall_override),
        .proto_err              (proto_err),
        .stall_cycles           (stall_cycles),
        .entries_written        (entries_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         v;
        logic [31:0]  d;
        logic         sop;
        logic         eop;
        logic [5:0]   tag;
        logic         exp_rdy;
        logic         exp_val;
        logic [105:0] exp_fifo;
        logic         exp_perr;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [105:0] mk(input logic s, input logic e, input logic [1:0] n,
                                        input logic [5:0] t, input logic [31:0] w2,
                                        input logic [31:0] w1, input logic [31:0] w0);
        return {s, e, n, t, w2, w1, w0};
    endfunction

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
        end
    endtask

    task automatic chk_ent(input string name, input logic [105:0] act, input logic [105:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_cnt(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic s, input logic e,
                         input logic [5:0] t);
        in_valid = v;
        in_data  = d;
        in_sop   = s;
        in_eop   = e;
        in_tag   = t;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 6'h0);
    endtask

    task automatic add_vec(input logic v, input logic [31:0] d, input logic s, input logic e,
                           input logic [5:0] t, input logic rdy, input logic val,
                           input logic [105:0] f, input logic perr);
        vec_t x;
        x.v = v; x.d = d; x.sop = s; x.eop = e; x.tag = t;
        x.exp_rdy = rdy; x.exp_val = val; x.exp_fifo = f; x.exp_perr = perr;
        tbl.push_back(x);
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        idle();
        fifo_in_stall      = 1'b0;
        cfg_stall_override = 1'b0;
        step();
        rst_n = 1'b1;
        chk_bit({name, "_rdy"}, in_ready, 1'b1);
        chk_bit({name, "_val"}, fifo_in_valid, 1'b0);
        chk_ent({name, "_fifo"}, fifo_in, 106'h0);
        chk_bit({name, "_perr"}, proto_err, 1'b0);
        chk_bit({name, "_ovr"}, fifo_in_stall_override, 1'b0);
        chk_cnt({name, "_stallcnt"}, 16'(stall_cycles), 16'd0);
        chk_cnt({name, "_entcnt"}, entries_written, 16'd0);
    endtask

    logic [105:0] e_t1, e1, e2, e3, ex, ey, er, eq, et;
    logic [31:0]  yw [3];

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        fifo_in_stall      = 1'b0;
        cfg_stall_override = 1'b0;
        idle();

        // ---------------- table: 3-word packet then 7-word packet ----------
        e_t1 = mk(1, 1, 2, 6'h2A, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000);
        e1   = mk(1, 0, 2, 6'h15, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000);
        e2   = mk(0, 0, 2, 6'h15, 32'hA000_0005, 32'hA000_0004, 32'hA000_0003);
        e3   = mk(0, 1, 0, 6'h15, 32'h0, 32'h0, 32'hA000_0006);

        add_vec(1, 32'h1111_0000, 1, 0, 6'h2A, 1, 0, 106'h0, 0);
        add_vec(1, 32'h2222_0001, 0, 0, 6'h3F, 1, 0, 106'h0, 0);
        add_vec(1, 32'h3333_0002, 0, 1, 6'h3F, 1, 0, 106'h0, 0);
        add_vec(0, 32'h0,         0, 0, 6'h00, 1, 1, e_t1,   0);
        add_vec(0, 32'h0,         0, 0, 6'h00, 1, 0, e_t1,   0);
        add_vec(1, 32'hA000_0000, 1, 0, 6'h15, 1, 0, e_t1,   0);
        add_vec(1, 32'hA000_0001, 0, 0, 6'h3F, 1, 0, e_t1,   0);
        add_vec(1, 32'hA000_0002, 0, 0, 6'h3F, 1, 0, e_t1,   0);
        add_vec(1, 32'hA000_0003, 0, 0, 6'h3F, 1, 1, e1,     0);
        add_vec(1, 32'hA000_0004, 0, 0, 6'h3F, 1, 0, e1,     0);
        add_vec(1, 32'hA000_0005, 0, 0, 6'h3F, 1, 0, e1,     0);
        add_vec(1, 32'hA000_0006, 0, 1, 6'h3F, 1, 1, e2,     0);
        add_vec(0, 32'h0,         0, 0, 6'h00, 1, 1, e3,     0);
        add_vec(0, 32'h0,         0, 0, 6'h00, 1, 0, e3,     0);

        do_reset("rst0");
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].sop, tbl[i].eop, tbl[i].tag);
            #1;
            chk_bit($sformatf("vec%0d_rdy", i), in_ready, tbl[i].exp_rdy);
            chk_bit($sformatf("vec%0d_val", i), fifo_in_valid, tbl[i].exp_val);
            chk_ent($sformatf("vec%0d_fifo", i), fifo_in, tbl[i].exp_fifo);
            chk_bit($sformatf("vec%0d_perr", i), proto_err, tbl[i].exp_perr);
            step();
        end
        chk_cnt("tbl_entcnt", entries_written, 16'd4);

        // ---------------- stall with a second entry completing -------------
        do_reset("rst1");
        ex = mk(1, 1, 2, 6'h11, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000);
        ey = mk(1, 1, 2, 6'h22, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000);
        yw[0] = 32'hC000_0000; yw[1] = 32'hC000_0001; yw[2] = 32'hC000_0002;
        fifo_in_stall = 1'b1;
        drive(1, 32'hB000_0000, 1, 0, 6'h11); step();
        drive(1, 32'hB000_0001, 0, 0, 6'h00); step();
        drive(1, 32'hB000_0002, 0, 1, 6'h00); step();
        for (int k = 0; k < 10; k++) begin
            if (k < 3) drive(1, yw[k], (k == 0), (k == 2), (k == 0) ? 6'h22 : 6'h00);
            else idle();
            #1;
            chk_bit($sformatf("stall%0d_val", k), fifo_in_valid, 1'b0);
            chk_ent($sformatf("stall%0d_fifo", k), fifo_in, ex);
            if (k >= 3) chk_bit($sformatf("stall%0d_rdy", k), in_ready, 1'b0);
            step();
        end
        chk_cnt("stall_cnt10", 16'(stall_cycles), 16'd10);
        fifo_in_stall = 1'b0;
        #1;
        chk_bit("unstall_val_x", fifo_in_valid, 1'b1);
        chk_ent("unstall_fifo_x", fifo_in, ex);
        step();
        chk_bit("unstall_val_y", fifo_in_valid, 1'b1);
        chk_ent("unstall_fifo_y", fifo_in, ey);
        chk_bit("unstall_rdy", in_ready, 1'b1);
        step();
        chk_bit("unstall_val_done", fifo_in_valid, 1'b0);
        chk_cnt("unstall_entcnt", entries_written, 16'd2);
        chk_cnt("unstall_stallcnt", 16'(stall_cycles), 16'd10);

        // ---------------- protocol errors ----------------------------------
        do_reset("rst2");
        eq = mk(1, 1, 1, 6'h07, 32'h0, 32'hE000_0001, 32'hE000_0000);
        drive(1, 32'hDEAD_0000, 0, 0, 6'h01);
        #1;
        chk_bit("perr_stray_rdy", in_ready, 1'b1);
        chk_bit("perr_before", proto_err, 1'b0);
        step();
        chk_bit("perr_stray", proto_err, 1'b1);
        drive(1, 32'hD000_0000, 1, 0, 6'h05); step();
        chk_bit("perr_clear", proto_err, 1'b0);
        drive(1, 32'hD000_0001, 0, 0, 6'h00); step();
        drive(1, 32'hE000_0000, 1, 0, 6'h07); step();
        chk_bit("perr_midsop", proto_err, 1'b1);
        drive(1, 32'hE000_0001, 0, 1, 6'h00); step();
        chk_bit("perr_after", proto_err, 1'b0);
        chk_bit("perr_val", fifo_in_valid, 1'b1);
        chk_ent("perr_fifo", fifo_in, eq);
        idle(); step();
        chk_bit("perr_val_done", fifo_in_valid, 1'b0);
        chk_cnt("perr_entcnt", entries_written, 16'd1);

        // ---------------- stall override and counter saturation ------------
        do_reset("rst3");
        er = mk(1, 1, 0, 6'h03, 32'h0, 32'h0, 32'hF000_0000);
        fifo_in_stall = 1'b1;
        drive(1, 32'hF000_0000, 1, 1, 6'h03); step();
        idle();
        chk_bit("ovr_val_blocked", fifo_in_valid, 1'b0);
        for (int k = 0; k < 20; k++) step();
        chk_cnt("stall_saturate", 16'(stall_cycles), 16'd15);
        cfg_stall_override = 1'b1;
        #1;
        chk_bit("ovr_reg_lag", fifo_in_stall_override, 1'b0);
        chk_bit("ovr_val_lag", fifo_in_valid, 1'b0);
        step();
        chk_bit("ovr_reg", fifo_in_stall_override, 1'b1);
        chk_bit("ovr_val", fifo_in_valid, 1'b1);
        chk_ent("ovr_fifo", fifo_in, er);
        chk_cnt("stall_hold", 16'(stall_cycles), 16'd15);
        step();
        chk_bit("ovr_val_done", fifo_in_valid, 1'b0);
        chk_cnt("ovr_entcnt", entries_written, 16'd1);
        cfg_stall_override = 1'b0;
        fifo_in_stall      = 1'b0;

        // ---------------- reset mid-packet ---------------------------------
        do_reset("rst4");
        et = mk(1, 1, 1, 6'h30, 32'h0, 32'h7000_0001, 32'h7000_0000);
        drive(1, 32'h5000_0000, 1, 1, 6'h09); step();
        idle(); step();
        chk_cnt("pre_rst_entcnt", entries_written, 16'd1);
        drive(1, 32'h6000_0000, 1, 0, 6'h04); step();
        drive(1, 32'h6000_0001, 0, 0, 6'h00); step();
        do_reset("midrst");
        drive(1, 32'h7000_0000, 1, 0, 6'h30); step();
        chk_bit("fresh_perr", proto_err, 1'b0);
        drive(1, 32'h7000_0001, 0, 1, 6'h00); step();
        idle();
        chk_bit("fresh_val", fifo_in_valid, 1'b1);
        chk_ent("fresh_fifo", fifo_in, et);
        step();
        chk_cnt("fresh_entcnt", entries_written, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
